emmc_traffic_gen: RTL and testbench

// - Parametrised write/read-back traffic generator for emmc_sm user interface; successor to the fixed incrementing-byte test driver.
// - Per loop: writes BLK_CNT blocks of a selectable pattern, reads them back, compares, counts mismatches; repeats LOOPS times or forever.
// - Sits between vio/testbench control and emmc_sm in the test core, on clk_core.

---
 rtl/emmc_tg_pkg.sv | 37 +++
 rtl/emmc_pattern_gen.sv | 54 +++++
 rtl/emmc_traffic_gen.sv | 215 +++++++++++++++++++++
 tb/tb_emmc_traffic_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/emmc_tg_pkg.sv
// Shared types and helpers for the eMMC write/read-back traffic generator.
package emmc_tg_pkg;

    // Data pattern selected by mode_i
    typedef enum logic [1:0] {
        MODE_INC  = 2'b00,
        MODE_LFSR = 2'b01,
        MODE_WALK = 2'b10,
        MODE_ALT  = 2'b11
    } mode_e;

    // Run sequencer states; IDLE is encoded as zero so a reset state reads 0
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_RUN = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_RUN = 3'd4,
        ST_LOOP   = 3'd5,
        ST_FIN    = 3'd6
    } state_e;

    // Galois (right-shifting) maximal-length feedback masks
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            16:      return 32'h0000_B400;
            32:      return 32'h8020_0003;
            default: return 32'h0000_00B8;
        endcase
    endfunction

    // Data beats needed to move one block
    function automatic int beats_per_blk(input int blk_bytes, input int data_w);
        return (blk_bytes * 8) / data_w;
    endfunction

endpackage

// File: rtl/emmc_pattern_gen.sv
// Data pattern generator: load a seed, then step once per advance.
module emmc_pattern_gen
    import emmc_tg_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              srst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] seed_i,
    input  mode_e             mode_i,
    input  logic              advance_i,
    output logic [DATA_W-1:0] value_o
);

    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

    logic [DATA_W-1:0] r_val;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] w_load;

    // Next pattern value for the selected mode
    always_comb begin
        w_next = r_val;
        case (mode_i)
            MODE_INC:  w_next = r_val + DATA_W'(1);
            MODE_LFSR: w_next = (r_val >> 1) ^ (r_val[0] ? TAPS : '0);
            MODE_WALK: w_next = {r_val[DATA_W-2:0], r_val[DATA_W-1]};
            default:   w_next = ~r_val;
        endcase
    end

    // An all-zero LFSR would lock up, so a zero seed becomes 1 in that mode
    always_comb begin
        w_load = seed_i;
        if (mode_i == MODE_LFSR && seed_i == '0) begin
            w_load = {{(DATA_W-1){1'b0}}, 1'b1};
        end
    end

    // Pattern register: load has priority over advance
    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            r_val <= '0;
        end else if (load_i) begin
            r_val <= w_load;
        end else if (advance_i) begin
            r_val <= w_next;
        end
    end

    assign value_o = r_val;

endmodule

// File: rtl/emmc_traffic_gen.sv
// Write/read-back traffic generator driving the emmc_sm user interface.
//
// Handshake with emmc_sm: while ready_i=1 the core is idle and a single-cycle
// start_o (with we_o and blk_cnt_o stable) launches a transfer. The transfer is
// finished once ready_i has been seen low and then high again. Each dvalid_i
// during a transfer is one beat: dat_o consumed on writes, dat_i valid on reads.
module emmc_traffic_gen
    import emmc_tg_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BLK_BYTES = 512,
    parameter int BLK_CNT_W = 16,
    parameter int ERR_CNT_W = 16,
    parameter int TIMEOUT   = 2**20
) (
    input  logic                 clk_i,
    input  logic                 srst_ni,
    input  logic                 go_i,
    input  logic [1:0]           mode_i,
    input  logic [DATA_W-1:0]    seed_i,
    input  logic [BLK_CNT_W-1:0] blk_cnt_i,
    input  logic [15:0]          loops_i,
    output logic                 we_o,
    output logic                 start_o,
    output logic [BLK_CNT_W-1:0] blk_cnt_o,
    output logic [DATA_W-1:0]    dat_o,
    input  logic [DATA_W-1:0]    dat_i,
    input  logic                 dvalid_i,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [31:0]          first_err_o,
    output state_e               state_o
);

    localparam int             BPB     = beats_per_blk(BLK_BYTES, DATA_W);
    localparam logic [31:0]    TMO_LIM = 32'(TIMEOUT);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    state_e                 r_state;
    logic                   r_go_d;
    mode_e                  r_mode;
    logic [DATA_W-1:0]      r_seed;
    logic [BLK_CNT_W-1:0]   r_blk_cnt;
    logic [15:0]            r_loops;
    logic [15:0]            r_loop_cnt;
    logic [31:0]            r_beat_cnt;
    logic [31:0]            r_tmo_cnt;
    logic [ERR_CNT_W-1:0]   r_err_cnt;
    logic [31:0]            r_first_err;
    logic                   r_seen_low;
    logic                   r_we;
    logic                   r_start;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic                   r_timeout;

    logic                   w_go_rise;
    logic                   w_in_req;
    logic                   w_in_run;
    logic                   w_tmo_hit;
    logic                   w_run_done;
    logic [31:0]            w_beats_final;
    logic                   w_beat_err;
    logic                   w_data_err;
    logic [1:0]             w_err_add;
    logic [ERR_CNT_W:0]     w_err_sum;
    logic [ERR_CNT_W-1:0]   w_err_next;
    logic [DATA_W-1:0]      w_gen;

    assign w_go_rise     = go_i && !r_go_d;
    assign w_in_req      = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);
    assign w_in_run      = (r_state == ST_WR_RUN) || (r_state == ST_RD_RUN);
    assign w_tmo_hit     = (w_in_req || w_in_run) && (r_tmo_cnt == TMO_LIM);
    assign w_run_done    = w_in_run && r_seen_low && ready_i;
    assign w_beats_final = r_beat_cnt + 32'(dvalid_i && w_in_run);
    assign w_beat_err    = w_run_done && (w_beats_final != 32'(r_blk_cnt) * 32'(BPB));
    assign w_data_err    = (r_state == ST_RD_RUN) && dvalid_i && (dat_i != w_gen);

    // One generator serves both directions: reloaded from the seed in every
    // request state, so each write pass and its read-back see identical data
    emmc_pattern_gen #(.DATA_W(DATA_W)) u_pattern_gen (
        .clk_i     (clk_i),
        .srst_ni   (srst_ni),
        .load_i    (w_in_req),
        .seed_i    (r_seed),
        .mode_i    (r_mode),
        .advance_i (w_in_run && dvalid_i),
        .value_o   (w_gen)
    );

    // Saturating error accumulation (data mismatch and beat-count error may coincide)
    always_comb begin
        w_err_add  = {1'b0, w_data_err} + {1'b0, w_beat_err};
        w_err_sum  = {1'b0, r_err_cnt} + {{(ERR_CNT_W-1){1'b0}}, w_err_add};
        w_err_next = w_err_sum[ERR_CNT_W] ? ERR_MAX : w_err_sum[ERR_CNT_W-1:0];
    end

    // Run sequencer with its beat, loop, timeout and error counters
    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            r_state     <= ST_IDLE;
            r_go_d      <= 1'b0;
            r_mode      <= MODE_INC;
            r_seed      <= '0;
            r_blk_cnt   <= '0;
            r_loops     <= '0;
            r_loop_cnt  <= '0;
            r_beat_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '1;
            r_seen_low  <= 1'b0;
            r_we        <= 1'b0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_go_d    <= go_i;
            r_start   <= 1'b0;
            r_err_cnt <= w_err_next;
            if (w_data_err && r_first_err == '1) begin
                r_first_err <= r_beat_cnt;
            end
            if (w_in_run && dvalid_i) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
            if (w_in_req || w_in_run) begin
                r_tmo_cnt <= r_tmo_cnt + 32'd1;
            end
            if (w_in_run && !ready_i) begin
                r_seen_low <= 1'b1;
            end

            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (w_go_rise) begin
                        r_mode      <= mode_e'(mode_i);
                        r_seed      <= seed_i;
                        r_blk_cnt   <= (blk_cnt_i == '0) ? {{(BLK_CNT_W-1){1'b0}}, 1'b1} : blk_cnt_i;
                        r_loops     <= loops_i;
                        r_loop_cnt  <= '0;
                        r_err_cnt   <= '0;
                        r_first_err <= '1;
                        r_tmo_cnt   <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_state     <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ, ST_RD_REQ: begin
                    if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_state   <= ST_FIN;
                    end else if (ready_i) begin
                        r_start    <= 1'b1;
                        r_we       <= (r_state == ST_WR_REQ);
                        r_beat_cnt <= '0;
                        r_seen_low <= 1'b0;
                        r_state    <= (r_state == ST_WR_REQ) ? ST_WR_RUN : ST_RD_RUN;
                    end
                end
                ST_WR_RUN, ST_RD_RUN: begin
                    if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_state   <= ST_FIN;
                    end else if (w_run_done) begin
                        r_tmo_cnt <= '0;
                        r_state   <= (r_state == ST_WR_RUN) ? ST_RD_REQ : ST_LOOP;
                    end
                end
                ST_LOOP: begin
                    r_loop_cnt <= r_loop_cnt + 16'd1;
                    if ((r_loops == '0) ? !go_i : (r_loop_cnt + 16'd1 == r_loops)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (r_err_cnt == '0) && !r_timeout;
                        r_state <= ST_FIN;
                    end else begin
                        r_tmo_cnt <= '0;
                        r_state   <= ST_WR_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign we_o        = r_we;
    assign start_o     = r_start;
    assign blk_cnt_o   = r_blk_cnt;
    assign dat_o       = w_gen;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign timeout_o   = r_timeout;
    assign err_cnt_o   = r_err_cnt;
    assign first_err_o = r_first_err;
    assign state_o     = r_state;

endmodule

// File: tb/tb_emmc_traffic_gen.sv
// Bench for emmc_traffic_gen: emmc_sm modelled as a RAM with fixed latency.
module tb_emmc_traffic_gen;
  import emmc_tg_pkg::*;

  localparam int BPB = 512;
  localparam int LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic srst_n;

  // main DUT signals
  logic        go, we, start, dvalid, ready, busy, done, pass, tmo;
  logic [1:0]  mode;
  logic [7:0]  seed, dat_o, dat_i;
  logic [15:0] blk, loops, blk_o, err;
  logic [31:0] first;
  state_e      st;

  // timeout DUT signals (emmc_sm never returns ready)
  logic        go_t, we_t, start_t, busy_t, done_t, pass_t, tmo_t;
  logic        ready_t, dvalid_t;
  logic [7:0]  dat_o_t, dat_i_t;
  logic [15:0] blk_o_t, err_t;
  logic [31:0] first_t;
  state_e      st_t;

  emmc_traffic_gen u_dut (
    .clk_i(clk), .srst_ni(srst_n), .go_i(go), .mode_i(mode), .seed_i(seed),
    .blk_cnt_i(blk), .loops_i(loops), .we_o(we), .start_o(start), .blk_cnt_o(blk_o),
    .dat_o(dat_o), .dat_i(dat_i), .dvalid_i(dvalid), .ready_i(ready),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
    .err_cnt_o(err), .first_err_o(first), .state_o(st)
  );

  emmc_traffic_gen #(.TIMEOUT(64)) u_dut_tmo (
    .clk_i(clk), .srst_ni(srst_n), .go_i(go_t), .mode_i(2'b00), .seed_i(8'h00),
    .blk_cnt_i(16'd1), .loops_i(16'd1), .we_o(we_t), .start_o(start_t), .blk_cnt_o(blk_o_t),
    .dat_o(dat_o_t), .dat_i(dat_i_t), .dvalid_i(dvalid_t), .ready_i(ready_t),
    .busy_o(busy_t), .done_o(done_t), .pass_o(pass_t), .timeout_o(tmo_t),
    .err_cnt_o(err_t), .first_err_o(first_t), .state_o(st_t)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp, n_fail;
  logic [7:0]  exp_q[$];     // expected write data, in order
  logic [49:0] stat_q[$];    // expected {timeout, pass, first_err, err_cnt} per run
  logic [7:0]  mem [0:4095];
  int wr_starts, rd_starts, t_starts, wr_beats_seen, done_events;
  logic corrupt_en;
  int   corrupt_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_next(input logic [1:0] m, input logic [7:0] v);
    case (m)
      2'b00:   return v + 8'd1;
      2'b01:   return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
      2'b10:   return {v[6:0], v[7]};
      default: return ~v;
    endcase
  endfunction

  // ---------------- emmc_sm model ----------------
  initial begin : sm_model
    logic m_we, aborted;
    int   m_n;
    ready = 1'b1; dvalid = 1'b0; dat_i = '0;
    ready_t = 1'b0; dvalid_t = 1'b0; dat_i_t = '0;
    forever begin
      @(posedge clk); #1;
      if (srst_n && start) begin
        m_we = we; m_n = int'(blk_o) * BPB; aborted = 1'b0;
        ready = 1'b0;
        for (int k = 0; k < LAT; k++) begin
          @(posedge clk); #1;
          if (!srst_n) aborted = 1'b1;
        end
        for (int i = 0; i < m_n && !aborted; i++) begin
          if (!srst_n) begin
            aborted = 1'b1;
          end else begin
            dvalid = 1'b1;
            if (m_we) mem[i] = dat_o;
            else dat_i = mem[i] ^ ((corrupt_en && i == corrupt_idx) ? 8'h01 : 8'h00);
            @(posedge clk); #1;
          end
        end
        dvalid = 1'b0; dat_i = '0; ready = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (srst_n) begin
        if (start) begin
          if (we) wr_starts++;
          else rd_starts++;
        end
        if (start_t) t_starts++;
        if (dvalid && we) begin
          wr_beats_seen++;
          if (exp_q.size() == 0) check("wr_data_extra", 64'd1, 64'd0);
          else check("wr_data", 64'(dat_o), 64'(exp_q.pop_front()));
        end
        if (done && !done_prev) begin
          done_events++;
          check("wr_data_left", 64'(exp_q.size()), 64'd0);
          if (stat_q.size() == 0) check("status_unexpected", 64'd1, 64'd0);
          else check("status{tmo,pass,first,err}", 64'({tmo, pass, first, err}), 64'(stat_q.pop_front()));
        end
      end
      done_prev = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expect(input logic [1:0] m, input logic [7:0] s, input int nblk, input int passes);
    logic [7:0] v;
    for (int p = 0; p < passes; p++) begin
      v = (m == 2'b01 && s == 8'h00) ? 8'h01 : s;
      for (int i = 0; i < nblk * BPB; i++) begin
        exp_q.push_back(v);
        v = ref_next(m, v);
      end
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] s, input logic [15:0] b,
                        input logic [15:0] l);
    @(negedge clk);
    mode = m; seed = s; blk = b; loops = l;
    wr_starts = 0; rd_starts = 0; wr_beats_seen = 0;
    go = 1'b1;
  endtask

  task automatic wait_done(input string name, input int ev0);
    int cyc;
    cyc = 0;
    while (done_events == ev0 && cyc < 20000) begin
      @(negedge clk); cyc++;
    end
    if (done_events == ev0) check({name, "_done_wait"}, 64'd0, 64'd1);
  endtask

  task automatic run_one(input string name, input logic [1:0] m, input logic [7:0] s,
                         input logic [15:0] b, input logic [15:0] l, input int nblk,
                         input logic [15:0] e_err, input logic [31:0] e_first, input logic e_pass);
    int ev0;
    push_expect(m, s, nblk, int'(l));
    stat_q.push_back({1'b0, e_pass, e_first, e_err});
    ev0 = done_events;
    launch(m, s, b, l);
    wait_done(name, ev0);
    check({name, "_wr_starts"}, 64'(wr_starts), 64'(l));
    check({name, "_rd_starts"}, 64'(rd_starts), 64'(l));
    check({name, "_blk_cnt_o"}, 64'(blk_o), 64'(nblk));
    check({name, "_busy_at_fin"}, 64'(busy), 64'd0);
    @(negedge clk); go = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int cyc, ev0;
    n_cmp = 0; n_fail = 0; done_events = 0;
    wr_starts = 0; rd_starts = 0; t_starts = 0; wr_beats_seen = 0;
    corrupt_en = 1'b0; corrupt_idx = 0;
    srst_n = 1'b0; go = 1'b0; go_t = 1'b0;
    mode = 2'b00; seed = '0; blk = 16'd1; loops = 16'd1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_outputs", 64'({we, start, blk_o, dat_o, busy, done, pass, tmo, err}), 64'd0);
    check("rst_first_err", 64'(first), 64'hFFFF_FFFF);
    check("rst_state", 64'(st), 64'(ST_IDLE));
    srst_n = 1'b1;
    repeat (2) @(negedge clk);

    // incrementing, seed 0, one block, one loop
    run_one("inc", 2'b00, 8'h00, 16'd1, 16'd1, 1, 16'd0, 32'hFFFF_FFFF, 1'b1);
    // LFSR seed A5, three blocks, two loops
    run_one("lfsr", 2'b01, 8'hA5, 16'd3, 16'd2, 3, 16'd0, 32'hFFFF_FFFF, 1'b1);
    // LFSR zero seed replaced by 1
    run_one("lfsr0", 2'b01, 8'h00, 16'd1, 16'd1, 1, 16'd0, 32'hFFFF_FFFF, 1'b1);
    // walking one, blk_cnt 0 treated as 1
    run_one("walk", 2'b10, 8'h01, 16'd0, 16'd1, 1, 16'd0, 32'hFFFF_FFFF, 1'b1);
    // alternating ~gen
    run_one("alt", 2'b11, 8'h5A, 16'd1, 16'd1, 1, 16'd0, 32'hFFFF_FFFF, 1'b1);
    // read beat 100 corrupted in both loops
    corrupt_en = 1'b1; corrupt_idx = 100;
    run_one("corrupt", 2'b00, 8'h00, 16'd1, 16'd2, 1, 16'd2, 32'd100, 1'b0);
    corrupt_en = 1'b0;

    // timeout: ready never returns on the second instance
    @(negedge clk); go_t = 1'b1;
    cyc = 0;
    while (!tmo_t && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    check("tmo_flag", 64'(tmo_t), 64'd1);
    check("tmo_window", 64'(cyc >= 64 && cyc <= 70), 64'd1);
    check("tmo_fin", 64'({done_t, pass_t, busy_t}), 64'b100);
    repeat (50) @(negedge clk);
    check("tmo_no_start", 64'(t_starts), 64'd0);
    go_t = 1'b0;

    // reset in the middle of a write transfer
    push_expect(2'b00, 8'h00, 1, 1);
    stat_q.push_back({1'b0, 1'b1, 32'hFFFF_FFFF, 16'd0});
    launch(2'b00, 8'h00, 16'd1, 16'd1);
    cyc = 0;
    while (wr_beats_seen < 50 && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    check("midrst_in_wr_run", 64'(st), 64'(ST_WR_RUN));
    srst_n = 1'b0; go = 1'b0;
    @(negedge clk);
    check("midrst_outputs", 64'({we, start, blk_o, dat_o, busy, done, pass, tmo, err}), 64'd0);
    check("midrst_first_err", 64'(first), 64'hFFFF_FFFF);
    check("midrst_state", 64'(st), 64'(ST_IDLE));
    exp_q.delete(); stat_q.delete();
    srst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_one("post_rst", 2'b00, 8'h00, 16'd1, 16'd1, 1, 16'd0, 32'hFFFF_FFFF, 1'b1);

    // loops_i = 0: run until go_i drops during the third loop
    push_expect(2'b00, 8'h10, 1, 3);
    stat_q.push_back({1'b0, 1'b1, 32'hFFFF_FFFF, 16'd0});
    ev0 = done_events;
    launch(2'b00, 8'h10, 16'd1, 16'd0);
    cyc = 0;
    while (wr_starts < 3 && cyc < 10000) begin
      @(negedge clk); cyc++;
    end
    go = 1'b0;
    wait_done("loops0", ev0);
    check("loops0_wr_starts", 64'(wr_starts), 64'd3);
    check("loops0_rd_starts", 64'(rd_starts), 64'd3);
    repeat (20) @(negedge clk);
    check("loops0_no_restart", 64'(wr_starts), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
